// File: rtl/fu_issue_scheduler_if.sv
// Issue scheduler bundle: RS requests and control in, grants, free pulses and busy out.
// The master side is the reservation station; the slave side is the scheduler.
interface fu_issue_scheduler_if #(
  parameter int NUM_ALU    = 3,
  parameter int NUM_MULT   = 2,
  parameter int NUM_LOAD   = 1,
  parameter int NUM_STORE  = 1,
  parameter int NUM_BRANCH = 1,
  parameter int IDXW       = 2
);
  logic                  stall;
  logic                  squash;
  logic [NUM_ALU-1:0]    alu_req;
  logic [NUM_MULT-1:0]   mult_req;
  logic [NUM_LOAD-1:0]   load_req;
  logic [NUM_STORE-1:0]  store_req;
  logic [NUM_BRANCH-1:0] branch_req;
  logic                  grant_valid;
  logic [2:0]            grant_class;
  logic [IDXW-1:0]       grant_index;
  logic [NUM_ALU-1:0]    free_alu;
  logic [NUM_MULT-1:0]   free_mult;
  logic [NUM_LOAD-1:0]   free_load;
  logic [NUM_STORE-1:0]  free_store;
  logic [NUM_BRANCH-1:0] free_branch;
  logic [NUM_ALU-1:0]    fu_busy_alu;
  logic [NUM_MULT-1:0]   fu_busy_mult;

  modport master (
    output stall, squash, alu_req, mult_req,
    output load_req, store_req, branch_req,
    input  grant_valid, grant_class, grant_index,
    input  free_alu, free_mult, free_load,
    input  free_store, free_branch,
    input  fu_busy_alu, fu_busy_mult
  );

  modport slave (
    input  stall, squash, alu_req, mult_req,
    input  load_req, store_req, branch_req,
    output grant_valid, grant_class, grant_index,
    output free_alu, free_mult, free_load,
    output free_store, free_branch,
    output fu_busy_alu, fu_busy_mult
  );
endinterface

// File: rtl/fu_issue_scheduler.sv
// Issue scheduler: one grant per cycle, round-robin across five unit classes,
// per-unit occupancy tracking with completion free pulses.
module fu_issue_scheduler #(
  parameter int NUM_ALU    = 3,
  parameter int NUM_MULT   = 2,
  parameter int NUM_LOAD   = 1,
  parameter int NUM_STORE  = 1,
  parameter int NUM_BRANCH = 1,
  parameter int MULT_LAT   = 4,
  parameter int LOAD_LAT   = 2,
  parameter int IDXW       = 2
) (
  input logic clock,
  input logic reset,
  fu_issue_scheduler_if.slave bus
);
  localparam int MAXLAT = (MULT_LAT > LOAD_LAT) ? MULT_LAT : LOAD_LAT;
  localparam int CW = $clog2(MAXLAT + 1);
  localparam logic [2:0] C_ALU = 3'd0;
  localparam logic [2:0] C_MULT = 3'd1;
  localparam logic [2:0] C_LOAD = 3'd2;
  localparam logic [2:0] C_STORE = 3'd3;
  localparam logic [2:0] C_BRANCH = 3'd4;
  localparam logic [CW-1:0] ONE = CW'(1);

  logic [NUM_ALU-1:0]    busy_alu, free_alu;
  logic [NUM_MULT-1:0]   busy_mult, free_mult;
  logic [NUM_LOAD-1:0]   busy_load, free_load;
  logic [NUM_STORE-1:0]  busy_store, free_store;
  logic [NUM_BRANCH-1:0] busy_branch, free_branch;
  logic [NUM_ALU-1:0]    elig_alu, take_alu;
  logic [NUM_MULT-1:0]   elig_mult, take_mult;
  logic [NUM_LOAD-1:0]   elig_load, take_load;
  logic [NUM_STORE-1:0]  elig_store, take_store;
  logic [NUM_BRANCH-1:0] elig_branch, take_branch;
  logic [CW-1:0]         cnt_mult [NUM_MULT];
  logic [CW-1:0]         cnt_load [NUM_LOAD];

  logic            gv;
  logic [2:0]      gc;
  logic [IDXW-1:0] gi;
  logic [2:0]      rr;
  logic [7:0]      any;
  logic            found, go;
  logic [2:0]      win, scan;
  logic [IDXW-1:0] widx;

  function automatic logic [IDXW-1:0] lowest(input logic [31:0] v);
    logic [IDXW-1:0] r;
    r = '0;
    for (int i = 31; i >= 0; i--)
      if (v[i]) r = IDXW'(i);
    return r;
  endfunction

  function automatic logic [31:0] onehot(
    input logic en, input logic [IDXW-1:0] i);
    return en ? (32'd1 << i) : 32'd0;
  endfunction

  function automatic logic [2:0] wrap(
    input logic [2:0] p, input int k);
    int s;
    s = int'(p) + k;
    if (s >= 5) s = s - 5;
    return 3'(s);
  endfunction

  // The previous-edge grant mask covers the lag before the RS clears its req.
  always_comb begin
    elig_alu = bus.alu_req & ~busy_alu
      & ~NUM_ALU'(onehot(gv && gc == C_ALU, gi));
    elig_mult = bus.mult_req & ~busy_mult
      & ~NUM_MULT'(onehot(gv && gc == C_MULT, gi));
    elig_load = bus.load_req & ~busy_load
      & ~NUM_LOAD'(onehot(gv && gc == C_LOAD, gi));
    elig_store = bus.store_req & ~busy_store
      & ~NUM_STORE'(onehot(gv && gc == C_STORE, gi));
    elig_branch = bus.branch_req & ~busy_branch
      & ~NUM_BRANCH'(onehot(gv && gc == C_BRANCH, gi));
  end

  always_comb begin
    any = {3'b000, |elig_branch, |elig_store,
           |elig_load, |elig_mult, |elig_alu};
    found = 1'b0;
    win = C_ALU;
    scan = C_ALU;
    for (int k = 0; k < 5; k++) begin
      scan = wrap(rr, k);
      if (!found && any[scan]) begin
        found = 1'b1;
        win = scan;
      end
    end
  end

  always_comb begin
    case (win)
      C_ALU:    widx = lowest(32'(elig_alu));
      C_MULT:   widx = lowest(32'(elig_mult));
      C_LOAD:   widx = lowest(32'(elig_load));
      C_STORE:  widx = lowest(32'(elig_store));
      C_BRANCH: widx = lowest(32'(elig_branch));
      default:  widx = '0;
    endcase
    go = found && !bus.stall && !bus.squash;
    take_alu = NUM_ALU'(onehot(go && win == C_ALU, widx));
    take_mult = NUM_MULT'(onehot(go && win == C_MULT, widx));
    take_load = NUM_LOAD'(onehot(go && win == C_LOAD, widx));
    take_store = NUM_STORE'(onehot(go && win == C_STORE, widx));
    take_branch = NUM_BRANCH'(onehot(go && win == C_BRANCH, widx));
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      gv <= 1'b0;
      gc <= '0;
      gi <= '0;
      rr <= C_ALU;
      busy_alu <= '0;
      busy_mult <= '0;
      busy_load <= '0;
      busy_store <= '0;
      busy_branch <= '0;
      free_alu <= '0;
      free_mult <= '0;
      free_load <= '0;
      free_store <= '0;
      free_branch <= '0;
      for (int i = 0; i < NUM_MULT; i++) cnt_mult[i] <= '0;
      for (int i = 0; i < NUM_LOAD; i++) cnt_load[i] <= '0;
    end else begin
      // Single-cycle units always complete at the edge after their grant.
      free_alu <= busy_alu;
      free_store <= busy_store;
      free_branch <= busy_branch;
      busy_alu <= take_alu;
      busy_store <= take_store;
      busy_branch <= take_branch;
      for (int i = 0; i < NUM_MULT; i++) begin
        if (bus.squash) begin
          free_mult[i] <= busy_mult[i];
          busy_mult[i] <= 1'b0;
          cnt_mult[i] <= '0;
        end else if (take_mult[i]) begin
          free_mult[i] <= 1'b0;
          busy_mult[i] <= 1'b1;
          cnt_mult[i] <= CW'(MULT_LAT);
        end else begin
          free_mult[i] <= busy_mult[i] && cnt_mult[i] == ONE;
          if (busy_mult[i]) begin
            cnt_mult[i] <= cnt_mult[i] - ONE;
            if (cnt_mult[i] == ONE) busy_mult[i] <= 1'b0;
          end
        end
      end
      for (int i = 0; i < NUM_LOAD; i++) begin
        if (bus.squash) begin
          free_load[i] <= busy_load[i];
          busy_load[i] <= 1'b0;
          cnt_load[i] <= '0;
        end else if (take_load[i]) begin
          free_load[i] <= 1'b0;
          busy_load[i] <= 1'b1;
          cnt_load[i] <= CW'(LOAD_LAT);
        end else begin
          free_load[i] <= busy_load[i] && cnt_load[i] == ONE;
          if (busy_load[i]) begin
            cnt_load[i] <= cnt_load[i] - ONE;
            if (cnt_load[i] == ONE) busy_load[i] <= 1'b0;
          end
        end
      end
      gv <= go;
      gc <= go ? win : C_ALU;
      gi <= go ? widx : '0;
      if (bus.squash)
        rr <= C_ALU;
      else if (go)
        rr <= (win == C_BRANCH) ? C_ALU : win + 3'd1;
    end
  end

  assign bus.grant_valid = gv;
  assign bus.grant_class = gc;
  assign bus.grant_index = gi;
  assign bus.free_alu = free_alu;
  assign bus.free_mult = free_mult;
  assign bus.free_load = free_load;
  assign bus.free_store = free_store;
  assign bus.free_branch = free_branch;
  assign bus.fu_busy_alu = busy_alu;
  assign bus.fu_busy_mult = busy_mult;
endmodule

// File: tb/tb_fu_issue_scheduler.sv
// Bench for fu_issue_scheduler: directed scenarios plus random traffic
// checked every cycle against a per-unit remaining-cycles model.
module tb_fu_issue_scheduler;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  fu_issue_scheduler_if #(
    .NUM_ALU(3), .NUM_MULT(2), .NUM_LOAD(1),
    .NUM_STORE(1), .NUM_BRANCH(1), .IDXW(2)
  ) bus ();

  fu_issue_scheduler #(
    .NUM_ALU(3), .NUM_MULT(2), .NUM_LOAD(1),
    .NUM_STORE(1), .NUM_BRANCH(1),
    .MULT_LAT(4), .LOAD_LAT(2), .IDXW(2)
  ) dut (
    .clock(clk),
    .reset(rst_n),
    .bus(bus)
  );

  int num [5] = '{3, 2, 1, 1, 1};
  int lat [5] = '{1, 4, 2, 1, 1};
  int rem [5][3];
  bit efree [5][3];
  bit egv;
  int egc, egi, rr;
  int vectors = 0;
  int miscompares = 0;

  task automatic chk(input string name, input int act, input int exp);
    vectors++;
    if (act != exp) begin
      miscompares++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int c = 0; c < 5; c++)
      for (int u = 0; u < 3; u++) begin
        rem[c][u] = 0;
        efree[c][u] = 1'b0;
      end
    egv = 1'b0; egc = 0; egi = 0; rr = 0;
  endtask

  // Advance the model by one edge using the inputs currently on the bus.
  task automatic model_step();
    bit [2:0] rq [5];
    bit found;
    int wc, wi, c;
    rq[0] = bus.alu_req;
    rq[1] = 3'(bus.mult_req);
    rq[2] = 3'(bus.load_req);
    rq[3] = 3'(bus.store_req);
    rq[4] = 3'(bus.branch_req);
    found = 1'b0; wc = 0; wi = 0;
    for (int k = 0; k < 5; k++) begin
      c = (rr + k) % 5;
      for (int u = 0; u < num[c]; u++)
        if (!found && rq[c][u] && rem[c][u] == 0 &&
            !(egv && egc == c && egi == u)) begin
          found = 1'b1; wc = c; wi = u;
        end
    end
    for (int cc = 0; cc < 5; cc++)
      for (int u = 0; u < 3; u++) begin
        if (bus.squash) begin
          efree[cc][u] = rem[cc][u] > 0;
          rem[cc][u] = 0;
        end else begin
          efree[cc][u] = rem[cc][u] == 1;
          if (rem[cc][u] > 0) rem[cc][u]--;
        end
      end
    egv = 1'b0; egc = 0; egi = 0;
    if (bus.squash) rr = 0;
    else if (found && !bus.stall) begin
      egv = 1'b1; egc = wc; egi = wi;
      rem[wc][wi] = lat[wc];
      rr = (wc + 1) % 5;
    end
  endtask

  function automatic int fvec(input int c);
    int v = 0;
    for (int u = 0; u < num[c]; u++) if (efree[c][u]) v |= (1 << u);
    return v;
  endfunction

  function automatic int bvec(input int c);
    int v = 0;
    for (int u = 0; u < num[c]; u++) if (rem[c][u] > 0) v |= (1 << u);
    return v;
  endfunction

  task automatic compare();
    chk("grant_valid", int'(bus.grant_valid), int'(egv));
    chk("grant_class", int'(bus.grant_class), egc);
    chk("grant_index", int'(bus.grant_index), egi);
    chk("free_alu", int'(bus.free_alu), fvec(0));
    chk("free_mult", int'(bus.free_mult), fvec(1));
    chk("free_load", int'(bus.free_load), fvec(2));
    chk("free_store", int'(bus.free_store), fvec(3));
    chk("free_branch", int'(bus.free_branch), fvec(4));
    chk("busy_alu", int'(bus.fu_busy_alu), bvec(0));
    chk("busy_mult", int'(bus.fu_busy_mult), bvec(1));
  endtask

  task automatic step();
    model_step();
    @(posedge clk);
    #1;
    compare();
  endtask

  task automatic idle();
    bus.stall = 0; bus.squash = 0;
    bus.alu_req = 0; bus.mult_req = 0; bus.load_req = 0;
    bus.store_req = 0; bus.branch_req = 0;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    #1;
    model_reset();
    compare();
    @(posedge clk);
    #2;
    rst_n = 1'b1;
  endtask

  initial begin
    idle();
    model_reset();
    repeat (2) @(posedge clk);
    #2 rst_n = 1'b1;
    compare();

    // ALU entry 1 held until granted, then dropped.
    bus.alu_req = 3'b010;
    step();
    chk("s2_gv", int'(bus.grant_valid), 1);
    chk("s2_idx", int'(bus.grant_index), 1);
    bus.alu_req = 0;
    step();
    chk("s2_free", int'(bus.free_alu), 2);
    chk("s2_no_regrant", int'(bus.grant_valid), 0);
    step();

    // Both multipliers requested: unit 1 follows unit 0, unit 0 free after 4 edges.
    do_reset();
    bus.mult_req = 2'b11;
    step();
    chk("s4_first", int'(bus.grant_index), 0);
    step();
    chk("s4_second", int'(bus.grant_index), 1);
    step(); step();
    chk("s4_no_regrant", int'(bus.grant_valid), 0);
    step();
    chk("s4_free0", int'(bus.free_mult), 1);
    step();
    chk("s4_free1", int'(bus.free_mult), 2);
    chk("s4_regrant0", int'(bus.grant_valid), 1);
    bus.mult_req = 0;
    repeat (5) step();

    // Stall for three cycles while a load completes.
    bus.load_req = 1;
    step();
    chk("s5_load", int'(bus.grant_class), 2);
    bus.load_req = 0; bus.stall = 1; bus.alu_req = 1;
    step();
    chk("s5_stall1", int'(bus.grant_valid), 0);
    step();
    chk("s5_free_load", int'(bus.free_load), 1);
    step();
    chk("s5_stall3", int'(bus.grant_valid), 0);
    idle();
    step();

    // Reset dropped mid multiply: no free pulse ever appears for it.
    do_reset();
    bus.mult_req = 2'b01;
    step();
    bus.mult_req = 0;
    step();
    #2;
    do_reset();
    chk("s1_gv", int'(bus.grant_valid), 0);
    chk("s1_busy", int'(bus.fu_busy_mult), 0);
    repeat (6) begin
      step();
      chk("s1_no_free", int'(bus.free_mult), 0);
    end

    // Squash with a multiply and a load in flight and an ALU request pending.
    bus.mult_req = 2'b01;
    step();
    bus.mult_req = 0; bus.load_req = 1;
    step();
    bus.load_req = 0;
    step();
    bus.alu_req = 1; bus.squash = 1;
    step();
    chk("s6_gv", int'(bus.grant_valid), 0);
    chk("s6_free_mult", int'(bus.free_mult), 1);
    chk("s6_free_load", int'(bus.free_load), 1);
    bus.squash = 0; bus.load_req = 1;
    step();
    chk("s6_rr0", int'(bus.grant_class), 0);
    idle();
    step();

    // All classes requesting: rotation 0,1,2,3,4.
    do_reset();
    bus.alu_req = 3'b111; bus.mult_req = 2'b11;
    bus.load_req = 1; bus.store_req = 1; bus.branch_req = 1;
    for (int k = 0; k < 5; k++) begin
      step();
      chk("s3_rot", int'(bus.grant_class), k);
    end
    repeat (10) step();

    // Random traffic.
    for (int n = 0; n < 3000; n++) begin
      bus.alu_req = 3'($urandom);
      bus.mult_req = 2'($urandom);
      bus.load_req = 1'($urandom_range(0, 2) == 0);
      bus.store_req = 1'($urandom_range(0, 2) == 0);
      bus.branch_req = 1'($urandom_range(0, 2) == 0);
      bus.stall = ($urandom_range(0, 7) == 0);
      bus.squash = ($urandom_range(0, 31) == 0);
      if ($urandom_range(0, 499) == 0) begin
        #2;
        do_reset();
      end
      step();
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
